// File: rtl/vp_mem_pkg.sv
// Shared definitions for vertex processor data-memory clients.
// Holds default memory geometry and the burst controller state encoding.
package vp_mem_pkg;

    localparam int VP_ADDR_W     = 8;
    localparam int VP_DATA_W     = 128;
    localparam int VP_RBUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } burst_state_e;

endpackage

// File: rtl/dmem_rbuf.sv
// Two-entry read response buffer holding {last, data}.
// The head entry is presented combinationally and stays stable until popped.
module dmem_rbuf
    import vp_mem_pkg::*;
#(
    parameter int DATA_W = VP_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              push_last,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              head_last,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W:0] slot [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic            pop_ok;
    logic            push_ok;

    // A pop frees the head slot in the same cycle, so a full buffer can still accept a push.
    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    assign {head_last, head_data} = slot[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push_ok) begin
                slot[wr_ptr] <= {push_last, push_data};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/dmem_burst_ctrl.sv
// Burst load/store controller for the vertex processor data memory.
// Streams write beats into memory, or read beats out through a 2-entry
// response buffer that hides the memory's one-cycle read latency.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a burst command, cmd_ready high
// ST_WRITE | passing accepted write beats straight to memory
// ST_READ  | issuing read addresses while the buffer has room
// ST_DRAIN | all reads issued, waiting for the last beat to be taken
module dmem_burst_ctrl
    import vp_mem_pkg::*;
#(
    parameter int ADDR_W     = VP_ADDR_W,
    parameter int DATA_W     = VP_DATA_W,
    parameter int RBUF_DEPTH = VP_RBUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // Only a depth of two is supported; the issue limit below assumes it.
    localparam logic [2:0] RBUF_LIMIT = 3'(RBUF_DEPTH);

    burst_state_e      state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] beats_left;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        rb_count;
    logic              rb_head_last;
    logic [DATA_W-1:0] rb_head_data;
    logic              pop;
    logic              issue;
    logic              drain_done;
    logic [2:0]        occupancy;

    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign wr_ready    = (state == ST_WRITE);
    assign mem_we      = wr_ready && wr_valid;
    assign mem_addr    = addr_cnt;
    assign mem_data_in = wr_data;

    assign rd_valid = (rb_count != 2'd0);
    assign rd_data  = rb_head_data;
    assign rd_last  = rd_valid && rb_head_last;
    assign pop      = rd_valid && rd_ready;

    // Beats already owed to the buffer after this cycle's pop; an issue now lands one cycle later.
    assign occupancy  = {1'b0, rb_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == ST_READ) && (occupancy < RBUF_LIMIT);
    assign drain_done = !inflight && (rb_count == {1'b0, pop});

    dmem_rbuf #(
        .DATA_W (DATA_W)
    ) u_rbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_last (inflight_last),
        .push_data (mem_data_out),
        .pop       (pop),
        .count     (rb_count),
        .head_last (rb_head_last),
        .head_data (rb_head_data)
    );

    // Burst sequencing: address/beat counters, read-in-flight tracking and state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr_cnt      <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (beats_left == '0);
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_cnt   <= cmd_addr;
                        beats_left <= cmd_len;
                        state      <= cmd_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_valid) begin
                        addr_cnt <= addr_cnt + 1'b1;
                        if (beats_left == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_cnt <= addr_cnt + 1'b1;
                        if (beats_left == '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// Self-checking bench for dmem_burst_ctrl with a behavioural memory and
// a scoreboard built from the intended burst contents.
module tb_dmem_burst_ctrl;

    localparam int AW = 8;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    always #5 clk = ~clk;

    dmem_burst_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_we       (cmd_we),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .busy         (busy),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Data memory: synchronous write, registered read address.
    logic [DW-1:0] mem [256];
    logic [AW-1:0] raddr_q;
    int            cyc = 0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data_in;
        raddr_q <= mem_addr;
        cyc     <= cyc + 1;
    end
    assign mem_data_out = mem[raddr_q];

    // Model state
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wexp_t;
    typedef struct packed { logic last; logic [DW-1:0] d; } rexp_t;

    logic [DW-1:0] ref_mem [256];
    wexp_t         wq[$];
    rexp_t         rq[$];
    bit            wr_active = 1'b0;
    bit            rd_active = 1'b0;
    logic [AW-1:0] rd_start  = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Results captured by the directed tasks for literal checks
    logic [DW-1:0] rx_data [256];
    logic          rx_last [256];
    int            rx_cyc  [256];
    int            rx_n;
    logic [AW-1:0] w_first_addr, w_last_addr;
    int            w_first_cyc, w_last_cyc;

    function automatic logic [DW-1:0] beat_data(input logic [7:0] tag, input int i);
        logic [7:0] ib;
        ib = 8'(i);
        return {4{tag, ib, 16'hA5C3}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Per-cycle compare of DUT outputs against the model
    task automatic compare_loop();
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        int            consumed   = 0;
        logic [AW-1:0] d8;
        wexp_t         we_e;
        rexp_t         re_e;
        forever begin
            @(negedge clk);
            if (rst) begin
                wq.delete();
                rq.delete();
                prev_stall = 1'b0;
                consumed   = 0;
                continue;
            end
            chk("cmd_ready_vs_busy", cmd_ready, !busy);
            chk("wr_ready", wr_ready, wr_active);
            chk("mem_we", mem_we, wr_active && wr_valid);
            if (mem_we) begin
                if (wq.size() == 0) begin
                    fail("extra_write", "got a memory write, expected none");
                end else begin
                    we_e = wq.pop_front();
                    chk("wr_addr", mem_addr, we_e.a);
                    chk("wr_data", mem_data_in, we_e.d);
                end
            end
            if (!rd_active) begin
                consumed = 0;
            end else begin
                d8 = mem_addr - rd_start;
                chk("outstanding_le_2", (int'(d8) - consumed) > 2, 0);
            end
            if (prev_stall) begin
                chk("hold_valid", rd_valid, 1'b1);
                chk("hold_data", rd_data, prev_data);
            end
            if (!rd_valid) chk("rd_last_idle", rd_last, 1'b0);
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    fail("extra_read", "got a read beat, expected none");
                end else begin
                    re_e = rq.pop_front();
                    chk("rd_data", rd_data, re_e.d);
                    chk("rd_last", rd_last, re_e.last);
                end
                consumed++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send_cmd(input logic we, input logic [AW-1:0] addr, input logic [AW-1:0] len);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        chk("cmd_ready_at_cmd", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                            input logic [7:0] tag, input logic [15:0] pat, input int plen);
        int            acc = 0;
        int            k   = 0;
        logic [AW-1:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 8'(i);
            ref_mem[a] = beat_data(tag, i);
            wq.push_back({a, beat_data(tag, i)});
        end
        send_cmd(1'b1, addr, len);
        wr_active = 1'b1;
        while (acc <= int'(len) && k < 200) begin
            wr_valid = pat[k % plen];
            wr_data  = wr_valid ? beat_data(tag, acc) : '1;
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                if (acc == 0) begin
                    w_first_addr = mem_addr;
                    w_first_cyc  = cyc;
                end
                w_last_addr = mem_addr;
                w_last_cyc  = cyc;
                acc++;
            end
            @(posedge clk);
            #1;
            k++;
        end
        wr_valid  = 1'b0;
        wr_data   = '0;
        wr_active = 1'b0;
        if (acc <= int'(len)) fail("write_timeout", "burst did not accept all beats within 200 cycles");
        @(negedge clk);
        chk("write_end_busy", busy, 1'b0);
        chk("write_end_cmd_ready", cmd_ready, 1'b1);
        chk("write_queue_empty", wq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // abort_at >= 0 returns at the negedge where that many beats have been taken.
    task automatic do_read(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                           input logic [15:0] pat, input int plen, input int abort_at);
        int            k = 0;
        logic [AW-1:0] a;
        rx_n = 0;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 8'(i);
            rq.push_back({(i == int'(len)), ref_mem[a]});
        end
        send_cmd(1'b0, addr, len);
        rd_start  = addr;
        rd_active = 1'b1;
        while (rx_n <= int'(len) && k < 300) begin
            rd_ready = pat[k % plen];
            @(negedge clk);
            if (k < 2)  chk("no_early_rd_valid", rd_valid, 1'b0);
            if (k == 2) chk("first_rd_valid_cycle3", rd_valid, 1'b1);
            if (rd_valid && rd_ready) begin
                rx_data[rx_n] = rd_data;
                rx_last[rx_n] = rd_last;
                rx_cyc[rx_n]  = cyc;
                rx_n++;
            end
            if (abort_at >= 0 && rx_n == abort_at) return;
            @(posedge clk);
            #1;
            k++;
        end
        rd_ready  = 1'b0;
        rd_active = 1'b0;
        if (rx_n <= int'(len)) fail("read_timeout", "burst did not deliver all beats within 300 cycles");
        @(negedge clk);
        chk("read_end_busy", busy, 1'b0);
        chk("read_end_cmd_ready", cmd_ready, 1'b1);
        chk("read_queue_empty", rq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic main_seq();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_last", rd_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        @(posedge clk);
        #1;

        // Write burst then read-back
        do_write(8'h10, 8'd3, 8'h11, 16'hFFFF, 1);
        chk("wb_first_addr", w_first_addr, 8'h10);
        chk("wb_last_addr", w_last_addr, 8'h13);
        chk("wb_consecutive", w_last_cyc - w_first_cyc, 3);
        do_read(8'h10, 8'd3, 16'hFFFF, 1, -1);
        chk("rb_beats", rx_n, 4);
        chk("rb_d0", rx_data[0], 128'h1100A5C3_1100A5C3_1100A5C3_1100A5C3);
        chk("rb_d3", rx_data[3], 128'h1103A5C3_1103A5C3_1103A5C3_1103A5C3);
        chk("rb_last_d0", rx_last[0], 1'b0);
        chk("rb_last_d3", rx_last[3], 1'b1);
        chk("rb_consecutive", rx_cyc[3] - rx_cyc[0], 3);

        // Address wrap
        do_write(8'hFE, 8'd3, 8'h22, 16'hFFFF, 1);
        chk("wrap_first_addr", w_first_addr, 8'hFE);
        chk("wrap_last_addr", w_last_addr, 8'h01);
        do_read(8'hFE, 8'd3, 16'hFFFF, 1, -1);
        chk("wrap_d2", rx_data[2], 128'h2202A5C3_2202A5C3_2202A5C3_2202A5C3);
        chk("wrap_d3", rx_data[3], 128'h2203A5C3_2203A5C3_2203A5C3_2203A5C3);

        // Read backpressure: alternate ready, then hold it low 5 cycles
        do_write(8'h40, 8'd7, 8'h33, 16'hFFFF, 1);
        do_read(8'h40, 8'd7, 16'hE055, 16, -1);
        chk("bp_beats", rx_n, 8);
        for (int i = 0; i < 8; i++) chk("bp_order", rx_data[i], beat_data(8'h33, i));
        chk("bp_last_only_end", rx_last[6], 1'b0);

        // Write bubbles: wr_valid 1,0,0,1,1,0,1
        do_write(8'h80, 8'd3, 8'h44, 16'h0059, 7);
        chk("bub_last_addr", w_last_addr, 8'h83);
        chk("bub_span", w_last_cyc - w_first_cyc, 6);
        do_read(8'h80, 8'd3, 16'hFFFF, 1, -1);
        chk("bub_d1", rx_data[1], 128'h4401A5C3_4401A5C3_4401A5C3_4401A5C3);

        // Reset in the middle of a read burst
        do_read(8'h40, 8'd7, 16'hFFFF, 1, 2);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        rd_ready  = 1'b0;
        rd_active = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rd_valid", rd_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_mem_we", mem_we, 1'b0);
        @(posedge clk);
        #1;
        do_read(8'h43, 8'd0, 16'hFFFF, 1, -1);
        chk("single_beats", rx_n, 1);
        chk("single_data", rx_data[0], 128'h3303A5C3_3303A5C3_3303A5C3_3303A5C3);
        chk("single_last", rx_last[0], 1'b1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        fork
            compare_loop();
            main_seq();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_burst_ctrl.md
Name: dmem_burst_ctrl

Overview:
- Burst load/store controller that masters the vertex processor data memory: 128-bit data, 8-bit address, synchronous write, registered read address.
- Accepts one burst command at a time over valid/ready.
- Streams write beats from the pipeline into memory, or streams read beats out to the pipeline with backpressure.
- Hides the memory's 1-cycle read latency behind a 2-entry response buffer.

Parameters:
- ADDR_W, 8, memory address width; also the cmd_len width.
- DATA_W, 128, memory and stream data width.
- RBUF_DEPTH, 2, read response buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  beats minus 1 (0..255 means 1..256 beats).
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  downstream accepts read beat.
- rd_data  out  DATA_W  read beat data.
- rd_last  out  1  marks the final beat of a read burst.
- busy  out  1  state != IDLE.
- mem_we  out  1  to memory we.
- mem_addr  out  ADDR_W  to memory addr.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out; valid the cycle after the address is presented.

Behaviour:
- Reset values: state IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, rd_last=0, busy=0, mem_we=0, mem_addr=0. Address counter, beat counter, in-flight flag and buffer all cleared.
- Reset mid-burst abandons the burst: no further memory writes, buffered read beats discarded, cmd_ready=1 in the cycle after the reset edge.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_valid && cmd_ready loads addr_cnt=cmd_addr and beats_left=cmd_len.
  - Next state is WRITE if cmd_we, else READ.
- mem_addr = addr_cnt (registered counter); mem_data_in = wr_data (combinational pass-through).
- WRITE:
  - wr_ready=1; mem_we = wr_valid (combinational, WRITE state only).
  - Each accepted beat writes at that edge and increments addr_cnt.
  - Accepting the beat with beats_left==0 returns to IDLE. No bubbles of its own; gaps in wr_valid stall without advancing the address.
- READ, issue rule: issue (advance addr_cnt, set inflight) when rbuf_count + inflight − (rd_valid && rd_ready) < 2.
- READ, response timing:
  - Data issued in cycle t is valid on mem_data_out in cycle t+1 and is pushed into the buffer at the end of t+1.
  - Buffer head drives rd_data/rd_valid from cycle t+2.
  - First rd_valid appears 3 cycles after the cmd accept edge.
- READ, throughput and ordering: sustained 1 beat/cycle while rd_ready=1. Never more than 2 beats outstanding; no loss, duplication or reordering.
- READ → DRAIN: after issuing the beat with beats_left==0, go to DRAIN.
- DRAIN: return to IDLE once inflight=0 and the buffer is empty, i.e. the cycle after the last rd_valid && rd_ready.
- rd_last: travels with the last beat through the buffer; asserted with that beat only.
- Address arithmetic: addr_cnt increments modulo 2^ADDR_W (0xFF → 0x00); the burst continues across the wrap.
- cmd_len=0: single-beat burst with identical timing rules.
- Simultaneous push and pop on a full buffer is legal; count is unchanged.
- rd_data holds its value while rd_valid && !rd_ready.

Decomposition:
- Shared package vp_mem_pkg holds ADDR_W/DATA_W defaults and the state encoding constants (IDLE, WRITE, READ, DRAIN); the data memory and future memory clients reuse them.
- One sub-module: dmem_rbuf, a 2-entry synchronous FIFO of {last, data} with push/pop/count. It shares clk and rst.

Test Plan:
- Write burst: rst, then write addr 0x10, len 3, D0..D3 with wr_valid held high → mem_we high 4 consecutive cycles at mem_addr 0x10..0x13, then IDLE with cmd_ready=1.
- Read-back: read addr 0x10, len 3, rd_ready=1 → rd_valid from cycle 3 after accept, D0..D3 in 4 consecutive cycles, rd_last only on D3, busy low the cycle after.
- Wrap: write then read addr 0xFE, len 3 → accesses at 0xFE, 0xFF, 0x00, 0x01; read data matches written data.
- Read backpressure: read len 7; rd_ready alternates 1/0, then is held low 5 cycles → exactly 8 beats in order, no duplicates, at most 2 issued-but-unconsumed beats.
- Write bubbles: wr_valid pattern 1,0,0,1,1,0,1 on len 3 → mem_we only in wr_valid cycles, addresses strictly consecutive across gaps.
- Reset mid-read: assert rst at beat 2 of a len 7 read → next cycle rd_valid=0, busy=0, cmd_ready=1, mem_we=0; a following single-beat read (len 0) returns correct data with rd_last=1.
